// File: rtl/axis_separator_if.sv
// Valid/ready word stream bundle shared by the separator's input and outputs.
// The sink side has no use for last, so the slave modport leaves it out.
interface axis_separator_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axis_separator.sv
// Splits one valid/ready stream into two outputs by fixed-size word groups:
// TO_PORT_ZERO words to output 0, then TO_PORT_ONE words to output 1, repeating.
//
// state     | meaning
// PORT_ZERO | accepted words load slot 0, group of TO_PORT_ZERO
// PORT_ONE  | accepted words load slot 1, group of TO_PORT_ONE
module axis_separator #(
  parameter int DATA_WIDTH   = 16,
  parameter int TO_PORT_ZERO = 16,
  parameter int TO_PORT_ONE  = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  axis_separator_if.slave          i_axis,
  axis_separator_if.master         o_axis0,
  axis_separator_if.master         o_axis1
);
  localparam int MAXN = (TO_PORT_ZERO > TO_PORT_ONE) ? TO_PORT_ZERO : TO_PORT_ONE;
  localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam logic [CW-1:0] END0 = CW'(TO_PORT_ZERO - 1);
  localparam logic [CW-1:0] END1 = CW'(TO_PORT_ONE - 1);

  typedef enum logic {PORT_ZERO, PORT_ONE} sel_t;

  sel_t                  r_sel;
  logic [CW-1:0]         r_cnt;
  logic                  r_full0, r_full1;
  logic                  r_last0, r_last1;
  logic [DATA_WIDTH-1:0] r_data0, r_data1;

  logic w_sel_ready;
  logic w_accept;
  logic w_cnt_end;
  logic w_load0, w_load1;

  // Only the selected slot gates the input; the other keeps draining on its own.
  assign w_sel_ready = (r_sel == PORT_ZERO) ? (!r_full0 || o_axis0.ready)
                                            : (!r_full1 || o_axis1.ready);
  assign i_axis.ready = !rst && w_sel_ready;
  assign w_accept     = i_axis.valid && i_axis.ready;
  assign w_cnt_end    = (r_sel == PORT_ZERO) ? (r_cnt == END0) : (r_cnt == END1);
  assign w_load0      = w_accept && (r_sel == PORT_ZERO);
  assign w_load1      = w_accept && (r_sel == PORT_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel   <= PORT_ZERO;
      r_cnt   <= '0;
      r_full0 <= 1'b0;
      r_full1 <= 1'b0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
      r_data0 <= '0;
      r_data1 <= '0;
    end else begin
      if (w_accept) begin
        if (w_cnt_end) begin
          r_cnt <= '0;
          r_sel <= (r_sel == PORT_ZERO) ? PORT_ONE : PORT_ZERO;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      // A refill in the same cycle as a drain wins and keeps the slot full.
      if (w_load0) begin
        r_full0 <= 1'b1;
        r_data0 <= i_axis.data;
        r_last0 <= w_cnt_end;
      end else if (o_axis0.ready) begin
        r_full0 <= 1'b0;
      end

      if (w_load1) begin
        r_full1 <= 1'b1;
        r_data1 <= i_axis.data;
        r_last1 <= w_cnt_end;
      end else if (o_axis1.ready) begin
        r_full1 <= 1'b0;
      end
    end
  end

  assign o_axis0.valid = r_full0;
  assign o_axis0.data  = r_data0;
  assign o_axis0.last  = r_last0;
  assign o_axis1.valid = r_full1;
  assign o_axis1.data  = r_data1;
  assign o_axis1.last  = r_last1;
endmodule
